nios2_ocimem_arbiter: RTL

Sysclk-domain controller that shares the Nios II on-chip debug memory (OCI RAM, single-port, 1-cycle read latency) between two requesters. The first is the JTAG debug path, which issues single-cycle command pulses plus a 38-bit `jdo` word. The second is the CPU's debug-memory Avalon slave. The block sits between the debug-slave sysclk logic and the OCI RAM instance. It sequences JTAG address-load, auto-increment reads and writes, and arbitrates fairly against CPU accesses.

---
 rtl/nios2_ocimem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/nios2_ocimem_arbiter.sv
// nios2_ocimem_arbiter: fair sharing of the single-port OCI debug RAM between JTAG commands and the CPU Avalon slave
module nios2_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  output logic [DATA_W-1:0] MonDReg,
  output logic              mon_valid,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  typedef enum logic [2:0] {IDLE, J_WR, J_RD, J_RDW, C_WR, C_RD, C_RDW} state_t;
  state_t state;
  logic [ADDR_W-1:0] jaddr, slot_addr, cmd_addr, j_addr;
  logic [DATA_W-1:0] slot_data, j_data;
  logic slot_valid, slot_wr, last_grant, wren_q;
  logic cmd, slot_free, accept, drop, j_pend, j_wr, cpu_pend, grant_j;
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:DATA_W+3], jdo[1:0]};
  // Command acceptance and the JTAG request seen by the arbiter (slot contents, or the command arriving now)
  always_comb begin
    cmd       = take_action_ocimem_b | take_no_action_ocimem_a;
    slot_free = ~slot_valid | (state == J_WR) | (state == J_RDW);
    accept    = cmd & slot_free;
    drop      = cmd & ~slot_free;
    cmd_addr  = take_action_ocimem_a ? jdo[ADDR_W+1:2] : jaddr;
    j_pend    = slot_valid | accept;
    j_wr      = slot_valid ? slot_wr : take_action_ocimem_b;
    j_addr    = slot_valid ? slot_addr : cmd_addr;
    j_data    = slot_valid ? slot_data : jdo[DATA_W+2:3];
    cpu_pend  = av_read | av_write;
    grant_j   = j_pend & (~cpu_pend | ~last_grant);
  end
  // Reset gates the write strobe and the Avalon handshake so an op caught by reset has no effect
  assign ram_wren       = wren_q & ~reset;
  assign av_waitrequest = cpu_pend & (reset | ~((state == C_WR) | (state == C_RDW)));
  assign av_readdata    = (state == C_RDW && !reset) ? ram_rdata : '0;
  // JTAG address/slot bookkeeping and the arbitration FSM with registered RAM controls
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      slot_valid   <= 1'b0;
      slot_wr      <= 1'b0;
      slot_addr    <= '0;
      slot_data    <= '0;
      jaddr        <= '0;
      MonDReg      <= '0;
      mon_valid    <= 1'b0;
      jtag_overrun <= 1'b0;
      wren_q       <= 1'b0;
      last_grant   <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
    end else begin
      mon_valid    <= 1'b0;
      wren_q       <= 1'b0;
      jtag_overrun <= ~take_action_ocimem_a & (jtag_overrun | drop);
      if (accept) begin
        jaddr      <= cmd_addr + ADDR_W'(1);
        slot_valid <= 1'b1;
        slot_wr    <= take_action_ocimem_b;
        slot_addr  <= cmd_addr;
        slot_data  <= jdo[DATA_W+2:3];
      end else begin
        if (take_action_ocimem_a) jaddr <= jdo[ADDR_W+1:2];
        if (state == J_WR || state == J_RDW) slot_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (grant_j) begin
            state      <= j_wr ? J_WR : J_RD;
            ram_addr   <= j_addr;
            ram_wdata  <= j_data;
            wren_q     <= j_wr;
            last_grant <= 1'b1;
          end else if (cpu_pend) begin
            state      <= av_write ? C_WR : C_RD;
            ram_addr   <= av_address;
            ram_wdata  <= av_writedata;
            wren_q     <= av_write;
            last_grant <= 1'b0;
          end
        end
        J_RD:  state <= J_RDW;
        J_RDW: begin
          MonDReg   <= ram_rdata;
          mon_valid <= 1'b1;
          state     <= IDLE;
        end
        C_RD:  state <= C_RDW;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
